// File: rtl/pipeline_stage_buffer.sv
// Elastic inter-stage buffer: DEPTH-entry circular store with valid/ready handshake
// and synchronous flush. Ready is taken from registered occupancy only.
module pipeline_stage_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]       LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_CNT = COUNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[head_q];
  assign occupancy = count_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // Storage is left intact; zero count masks it through out_valid.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = in_data;
        tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = (head_q == LAST_IDX) ? '0 : head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + COUNT_WIDTH'(1);
        2'b01:   count_d = count_q - COUNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench for pipeline_stage_buffer at DEPTH 1, 2, 3 and 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipeline_stage_buffer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DEPTH=2 instance
  logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [63:0] d2_in_data, d2_out_data;
  logic [1:0]  d2_occ;
  // DEPTH=4 instance
  logic        d4_flush, d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [63:0] d4_in_data, d4_out_data;
  logic [2:0]  d4_occ;
  // DEPTH=3 instance
  logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [63:0] d3_in_data, d3_out_data;
  logic [1:0]  d3_occ;
  // DEPTH=1 instance
  logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [63:0] d1_in_data, d1_out_data;
  logic [0:0]  d1_occ;

  pipeline_stage_buffer #(.DATA_WIDTH(64), .DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .flush(d2_flush),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data),
    .occupancy(d2_occ));

  pipeline_stage_buffer #(.DATA_WIDTH(64), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .flush(d4_flush),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
    .occupancy(d4_occ));

  pipeline_stage_buffer #(.DATA_WIDTH(64), .DEPTH(3)) dut3 (
    .clock(clock), .reset(reset), .flush(d3_flush),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data),
    .occupancy(d3_occ));

  pipeline_stage_buffer #(.DATA_WIDTH(64), .DEPTH(1)) dut1 (
    .clock(clock), .reset(reset), .flush(d1_flush),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .occupancy(d1_occ));

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (d2_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", d2_out_valid); end
    checks++; if (d2_occ !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", d2_occ); end
    checks++; if (d2_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", d2_in_ready); end
    checks++; if (d2_out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", d2_out_data); end
    checks++; if (d4_in_ready !== 1'b1 || d4_occ !== 3'd0) begin errors++; $display("FAIL reset_d4: ready %b occ %0d expected 1/0", d4_in_ready, d4_occ); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (d2_out_valid !== 1'b0 || d2_occ !== 2'd0) begin errors++; $display("FAIL idle_after_reset: valid %b occ %0d expected 0/0", d2_out_valid, d2_occ); end
  endtask

  task automatic test_single_transfer();
    d2_in_valid = 1'b1; d2_in_data = 64'hBFC00000_3C010001; d2_out_ready = 1'b0;
    @(negedge clock);
    d2_in_valid = 1'b0;
    checks++; if (d2_out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %b expected 1", d2_out_valid); end
    checks++; if (d2_out_data !== 64'hBFC00000_3C010001) begin errors++; $display("FAIL single_out_data: got %h expected bfc000003c010001", d2_out_data); end
    checks++; if (d2_occ !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d expected 1", d2_occ); end
    d2_out_ready = 1'b1;
    @(negedge clock);
    d2_out_ready = 1'b0;
    checks++; if (d2_occ !== 2'd0 || d2_out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: occ %0d valid %b expected 0/0", d2_occ, d2_out_valid); end
    @(negedge clock);
    checks++; if (d2_occ !== 2'd0) begin errors++; $display("FAIL empty_pop_hold: occ %0d expected 0", d2_occ); end
  endtask

  task automatic test_fill_backpressure();
    d4_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d4_in_valid = 1'b1; d4_in_data = 64'(i);
      @(negedge clock);
    end
    d4_in_data = 64'd5;
    checks++; if (d4_occ !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d expected 4", d4_occ); end
    checks++; if (d4_in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", d4_in_ready); end
    @(negedge clock);
    d4_in_valid = 1'b0;
    checks++; if (d4_occ !== 3'd4 || d4_out_data !== 64'd1) begin errors++; $display("FAIL fill_reject: occ %0d head %h expected 4/1", d4_occ, d4_out_data); end
    d4_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (d4_out_valid !== 1'b1 || d4_out_data !== 64'(i)) begin errors++; $display("FAIL drain_%0d: valid %b data %h expected 1/%h", i, d4_out_valid, d4_out_data, 64'(i)); end
      @(negedge clock);
    end
    d4_out_ready = 1'b0;
    checks++; if (d4_out_valid !== 1'b0 || d4_occ !== 3'd0) begin errors++; $display("FAIL drain_empty: valid %b occ %0d expected 0/0", d4_out_valid, d4_occ); end
  endtask

  task automatic test_stream_wrap();
    d3_in_valid = 1'b1; d3_in_data = 64'd0; d3_out_ready = 1'b0;
    @(negedge clock);
    d3_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 9) d3_in_data = 64'(k + 1);
      else d3_in_valid = 1'b0;
      checks++; if (d3_occ !== 2'd1 || d3_out_valid !== 1'b1 || d3_out_data !== 64'(k)) begin errors++; $display("FAIL stream_%0d: occ %0d valid %b data %h expected 1/1/%h", k, d3_occ, d3_out_valid, d3_out_data, 64'(k)); end
      @(negedge clock);
    end
    d3_out_ready = 1'b0;
    checks++; if (d3_occ !== 2'd0 || d3_out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: occ %0d valid %b expected 0/0", d3_occ, d3_out_valid); end
  endtask

  task automatic test_full_pop_same_cycle();
    d1_in_valid = 1'b1; d1_in_data = 64'hA1; d1_out_ready = 1'b0;
    @(negedge clock);
    d1_in_data = 64'hB2; d1_out_ready = 1'b1;
    checks++; if (d1_in_ready !== 1'b0 || d1_out_data !== 64'hA1) begin errors++; $display("FAIL d1_full: ready %b data %h expected 0/a1", d1_in_ready, d1_out_data); end
    @(negedge clock);
    d1_out_ready = 1'b0;
    checks++; if (d1_occ !== 1'd0 || d1_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin errors++; $display("FAIL d1_pop_no_push: occ %0d valid %b ready %b expected 0/0/1", d1_occ, d1_out_valid, d1_in_ready); end
    @(negedge clock);
    d1_in_valid = 1'b0; d1_out_ready = 1'b1;
    checks++; if (d1_occ !== 1'd1 || d1_out_data !== 64'hB2) begin errors++; $display("FAIL d1_next_push: occ %0d data %h expected 1/b2", d1_occ, d1_out_data); end
    @(negedge clock);
    d1_out_ready = 1'b0;
    checks++; if (d1_occ !== 1'd0) begin errors++; $display("FAIL d1_final: occ %0d expected 0", d1_occ); end
  endtask

  task automatic test_flush_and_reset();
    logic [63:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    d4_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d4_in_valid = 1'b1; d4_in_data = vals[i];
      @(negedge clock);
    end
    checks++; if (d4_occ !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d expected 3", d4_occ); end
    d4_flush = 1'b1; d4_in_data = 64'h44; d4_out_ready = 1'b1;
    @(negedge clock);
    d4_flush = 1'b0; d4_in_valid = 1'b0; d4_out_ready = 1'b0;
    checks++; if (d4_occ !== 3'd0 || d4_out_valid !== 1'b0 || d4_in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: occ %0d valid %b ready %b expected 0/0/1", d4_occ, d4_out_valid, d4_in_ready); end
    d4_in_valid = 1'b1; d4_in_data = 64'h55;
    @(negedge clock);
    d4_in_data = 64'h66;
    @(negedge clock);
    d4_in_valid = 1'b0;
    checks++; if (d4_occ !== 3'd2 || d4_out_data !== 64'h55) begin errors++; $display("FAIL refill: occ %0d head %h expected 2/55", d4_occ, d4_out_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (d4_out_valid !== 1'b0 || d4_occ !== 3'd0 || d4_out_data !== 64'd0) begin errors++; $display("FAIL async_reset: valid %b occ %0d data %h expected 0/0/0", d4_out_valid, d4_occ, d4_out_data); end
    @(negedge clock);
    reset = 1'b0;
    d4_in_valid = 1'b1; d4_in_data = 64'h77;
    @(negedge clock);
    d4_in_valid = 1'b0;
    checks++; if (d4_occ !== 3'd1 || d4_out_data !== 64'h77) begin errors++; $display("FAIL post_reset_push: occ %0d data %h expected 1/77", d4_occ, d4_out_data); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    d2_flush = 1'b0; d2_in_valid = 1'b0; d2_in_data = '0; d2_out_ready = 1'b0;
    d4_flush = 1'b0; d4_in_valid = 1'b0; d4_in_data = '0; d4_out_ready = 1'b0;
    d3_flush = 1'b0; d3_in_valid = 1'b0; d3_in_data = '0; d3_out_ready = 1'b0;
    d1_flush = 1'b0; d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
    test_reset();
    test_single_transfer();
    test_fill_backpressure();
    test_stream_wrap();
    test_full_pop_same_cycle();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_buffer.md
Name: pipeline_stage_buffer

Overview:
- Parametrised inter-stage buffer for the five-stage core (IF/ID/EX/IO/WB).
- Replaces single-register stage latches with a DEPTH-entry elastic buffer carrying a flattened stage bus payload.
- Uses a valid/ready handshake and a synchronous flush for branch/exception squash.
- One instance sits between each pair of stages; the payload is the packed stage struct minus its valid bit.

Parameters:
- DATA_WIDTH, 64, payload width in bits (default fits program_count + instruction).
- DEPTH, 2, number of entries; any integer >= 1, not restricted to powers of two.
- COUNT_WIDTH, $clog2(DEPTH+1), width of the occupancy output; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream stage presents a payload.
- in_ready  output  1  buffer accepts a payload this cycle (allow-in).
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  head entry is valid toward the downstream stage.
- out_ready  input  1  downstream stage consumes the head this cycle.
- out_data  output  DATA_WIDTH  head entry payload.
- occupancy  output  COUNT_WIDTH  number of valid entries, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - DEPTH-entry circular store with head pointer, tail pointer and count register.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- Reset (asynchronous):
  - count=0, head=0, tail=0, all storage=0.
  - Therefore out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Derived outputs:
  - in_ready = (count != DEPTH), derived from registered state only; it has no combinational dependence on out_ready.
  - out_valid = (count != 0); out_data = storage[head]; occupancy = count.
  - There is no combinational path from in_* to out_*.
- Events:
  - push = in_valid & in_ready & ~flush; writes storage[tail] and advances tail.
  - pop = out_valid & out_ready & ~flush; advances head.
  - count' = count + push - pop.
- Latency: a payload pushed at edge N is visible on out_data/out_valid after edge N, i.e. one cycle minimum, even when the buffer is empty.
- Simultaneous push and pop (count between 1 and DEPTH-1): both occur and count is unchanged.
- Full with out_ready=1: the pop occurs but in_ready stays 0 that cycle. in_ready rises the next cycle. Sustained full throughput at DEPTH=1 is therefore one transfer per two cycles; this is a decided consequence of the registered-ready rule.
- Empty with out_ready=1: no pop, count stays 0, head does not move.
- in_valid while in_ready=0: ignored, no state change; upstream holds its payload.
- Flush (highest priority, synchronous):
  - Next edge gives count=0 and head=tail=0.
  - A push or pop in the same cycle is discarded.
  - Storage contents are not cleared, but out_valid=0 masks them.
  - in_ready=1 from the following cycle.
- Reset during operation: reset asserted asynchronously mid-stream returns all state to reset values immediately. The first push after deassertion behaves as from an empty buffer.
- Payload handling:
  - Payload bits are stored and forwarded unmodified; no width conversion.
  - The payload's own valid field, if present, is not interpreted by the buffer.

Test Plan:
- Reset then idle: after reset, out_valid=0, occupancy=0, in_ready=1, out_data=0.
- Single transfer (DEPTH=2): push 0xBFC00000_3C010001 at edge 1 with out_ready=0. Expect out_valid=1 and out_data=0xBFC00000_3C010001 after edge 1, occupancy=1. Pulse out_ready: occupancy=0.
- Fill and backpressure (DEPTH=4): push 1,2,3,4 on consecutive cycles with out_ready=0. Expect occupancy=4 and in_ready=0; a fifth in_valid with data 5 is not accepted. Then drain with out_ready=1: out_data sequence is 1,2,3,4, then out_valid=0.
- Streaming and wrap (DEPTH=3): hold in_valid=1 and out_ready=1 with data 0..9 after one initial push. Expect occupancy constant at 1, outputs in order 0..9 with no loss or duplication, and both pointers wrapping past index 2 at least 3 times.
- Full plus pop same cycle (DEPTH=1): occupancy=1, out_ready=1, in_valid=1. Expect the pop and no push that cycle (in_ready=0); the push is accepted the next cycle.
- Flush and reset mid-operation (DEPTH=4): with occupancy=3, assert flush together with in_valid=1 and out_ready=1. Expect occupancy=0 and out_valid=0 next cycle, with the pushed datum discarded. Refill to 2, then assert reset between clock edges: out_valid=0 immediately.
